// File: rtl/risc_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : risc_control_unit_if
// Description : Bus between the RISC control unit and its datapath plus the
//               instruction ROM and data RAM strobes.
//               master modport : control unit side (drives selects/strobes)
//               slave  modport : datapath / memory side
//   imem_addr/imem_data : instruction ROM address / data (data 1 cycle later)
//   V,C,N,Z, A_out      : datapath ALU flags and bus A
//   MD,RW,ASEL,MB,FS,SA,DR,BA,imdt,PC : datapath selects
//   ram_addr, ram_we    : data RAM address and write strobe
// Revision    : 1.0 - initial release
// ============================================================================
interface risc_control_unit_if #(
    parameter int PC_W = 6
);
    logic [15:0]     imem_data;
    logic [PC_W-1:0] imem_addr;
    logic            V;
    logic            C;
    logic            N;
    logic            Z;
    logic [15:0]     A_out;
    logic            MD;
    logic            RW;
    logic            ASEL;
    logic [1:0]      MB;
    logic [3:0]      FS;
    logic [3:0]      SA;
    logic [3:0]      DR;
    logic [3:0]      BA;
    logic [15:0]     imdt;
    logic [PC_W-1:0] PC;
    logic [15:0]     ram_addr;
    logic            ram_we;

    modport master (
        input  imem_data, V, C, N, Z, A_out,
        output imem_addr, MD, RW, ASEL, MB, FS, SA, DR, BA, imdt, PC,
               ram_addr, ram_we
    );

    modport slave (
        output imem_data, V, C, N, Z, A_out,
        input  imem_addr, MD, RW, ASEL, MB, FS, SA, DR, BA, imdt, PC,
               ram_addr, ram_we
    );
endinterface
`default_nettype wire

// File: rtl/risc_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : risc_control_unit
// Description : Multi-cycle FETCH/LOAD/EXEC/MEM/HALT sequencer for the 16-bit
//               RISC datapath. Owns PC, instruction register and ALU flags.
//   clk     : system clock, rising edge
//   reset   : asynchronous active-low reset
//   run     : 1 = allowed to leave FETCH
//   bus     : datapath / memory bus (master side)
//   halted  : 1 while in HALT
//   flags   : latched {V,C,N,Z}
// Revision    : 1.0 - initial release
// ============================================================================
module risc_control_unit #(
    parameter int PC_W  = 6,
    parameter int IMM_W = 8
) (
    input  wire logic           clk,
    input  wire logic           reset,
    input  wire logic           run,
    risc_control_unit_if.master bus,
    output logic                halted,
    output logic [3:0]          flags
);

    localparam logic [3:0] c_OP_LDI  = 4'h8;
    localparam logic [3:0] c_OP_LD   = 4'h9;
    localparam logic [3:0] c_OP_ST   = 4'hA;
    localparam logic [3:0] c_OP_JAL  = 4'hB;
    localparam logic [3:0] c_OP_BZ   = 4'hC;
    localparam logic [3:0] c_OP_BN   = 4'hD;
    localparam logic [3:0] c_OP_JR   = 4'hE;
    localparam logic [3:0] c_OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_LOAD  = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;
    logic [15:0]     r_ir;
    logic [15:0]     w_ir_next;
    logic [3:0]      r_flags;
    logic [3:0]      w_flags_next;
    logic [15:0]     r_ram_addr;
    logic [15:0]     w_ram_addr_next;

    logic            w_md;
    logic            w_rw;
    logic            w_asel;
    logic [1:0]      w_mb;
    logic [3:0]      w_fs;
    logic [15:0]     w_imdt;
    logic            w_ram_we;
    logic            w_addr_bypass;

    // Instruction fields
    logic [3:0]       w_op;
    logic [PC_W-1:0]  w_tgt;
    logic [IMM_W-1:0] w_imm;
    assign w_op  = r_ir[15:12];
    assign w_tgt = r_ir[PC_W-1:0];
    assign w_imm = r_ir[IMM_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_FETCH;
            r_pc       <= '0;
            r_ir       <= '0;
            r_flags    <= '0;
            r_ram_addr <= '0;
        end else begin
            r_state    <= w_next_state;
            r_pc       <= w_pc_next;
            r_ir       <= w_ir_next;
            r_flags    <= w_flags_next;
            r_ram_addr <= w_ram_addr_next;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_pc_next       = r_pc;
        w_ir_next       = r_ir;
        w_flags_next    = r_flags;
        w_ram_addr_next = r_ram_addr;
        w_md            = 1'b0;
        w_rw            = 1'b0;
        w_asel          = 1'b0;
        w_mb            = 2'b00;
        w_fs            = 4'h0;
        w_imdt          = 16'h0000;
        w_ram_we        = 1'b0;
        w_addr_bypass   = 1'b0;

        case (r_state)
            S_FETCH: begin
                if (run) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                w_ir_next    = bus.imem_data;
                w_pc_next    = r_pc + 1'b1;   // wraps naturally at PC_W bits
                w_next_state = S_EXEC;
            end
            S_EXEC: begin
                w_next_state = S_FETCH;
                case (w_op)
                    4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                        w_fs         = {1'b0, w_op[2:0]};
                        w_rw         = 1'b1;
                        w_flags_next = {bus.V, bus.C, bus.N, bus.Z};
                    end
                    c_OP_LDI: begin
                        w_mb   = 2'b01;
                        w_imdt = {{(16-IMM_W){1'b0}}, w_imm};
                        w_rw   = 1'b1;
                    end
                    c_OP_LD: begin
                        w_addr_bypass   = 1'b1;
                        w_ram_addr_next = bus.A_out;
                        w_next_state    = S_MEM;
                    end
                    c_OP_ST: begin
                        w_asel          = 1'b1;
                        w_addr_bypass   = 1'b1;
                        w_ram_addr_next = bus.A_out;
                        w_ram_we        = 1'b1;
                    end
                    c_OP_JAL: begin
                        w_mb      = 2'b10;
                        w_rw      = 1'b1;
                        w_pc_next = w_tgt;
                    end
                    c_OP_BZ: begin
                        if (r_flags[0]) begin
                            w_pc_next = w_tgt;
                        end
                    end
                    c_OP_BN: begin
                        if (r_flags[1]) begin
                            w_pc_next = w_tgt;
                        end
                    end
                    c_OP_JR: begin
                        w_pc_next = bus.A_out[PC_W-1:0];
                    end
                    c_OP_HALT: begin
                        w_next_state = S_HALT;
                    end
                    default: begin
                        w_next_state = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                w_md         = 1'b1;
                w_rw         = 1'b1;
                w_next_state = S_FETCH;
            end
            S_HALT: begin
                w_next_state = S_HALT;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    // The RAM samples its address combinationally during EXEC, so the address
    // register is bypassed with A_out in that cycle; afterwards (MEM) the
    // captured value is presented.
    assign bus.ram_addr  = w_addr_bypass ? bus.A_out : r_ram_addr;
    assign bus.imem_addr = r_pc;
    assign bus.PC        = r_pc;
    assign bus.SA        = r_ir[7:4];
    assign bus.DR        = r_ir[11:8];
    assign bus.BA        = r_ir[3:0];
    assign bus.MD        = w_md;
    assign bus.RW        = w_rw;
    assign bus.ASEL      = w_asel;
    assign bus.MB        = w_mb;
    assign bus.FS        = w_fs;
    assign bus.imdt      = w_imdt;
    assign bus.ram_we    = w_ram_we;
    assign halted        = (r_state == S_HALT);
    assign flags         = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_risc_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_risc_control_unit
// Description : Table-driven bench for risc_control_unit. A small ROM model
//               holds a directed program; each table row gives the fetch
//               address, instruction, datapath stimulus and expected EXEC
//               outputs. Hand-written sequences cover reset mid-EXEC, run
//               stall and HALT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_risc_control_unit;

    logic       clk;
    logic       reset;
    logic       run;
    logic       halted;
    logic [3:0] flags;

    int checks;
    int failures;

    risc_control_unit_if #(.PC_W(6)) bus ();

    risc_control_unit #(.PC_W(6), .IMM_W(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .run    (run),
        .bus    (bus),
        .halted (halted),
        .flags  (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] rom [64];
    always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];

    typedef struct {
        logic [5:0]  addr;
        logic [15:0] instr;
        logic [15:0] a;
        logic [3:0]  vcnz;
        logic        rw;
        logic [1:0]  mb;
        logic        asel;
        logic [3:0]  fs;
        logic [3:0]  dr;
        logic [15:0] imdt;
        logic        we;
        logic [15:0] ram;
        logic [3:0]  flg;
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t mk(logic [5:0] addr, logic [15:0] instr,
                                logic [15:0] a, logic [3:0] vcnz, logic rw,
                                logic [1:0] mb, logic asel, logic [3:0] fs,
                                logic [3:0] dr, logic [15:0] imdt, logic we,
                                logic [15:0] ram, logic [3:0] flg);
        vec_t v;
        v.addr = addr; v.instr = instr; v.a = a; v.vcnz = vcnz; v.rw = rw;
        v.mb = mb; v.asel = asel; v.fs = fs; v.dr = dr; v.imdt = imdt;
        v.we = we; v.ram = ram; v.flg = flg;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        run      = 1'b0;
        bus.A_out = 16'h0000;
        {bus.V, bus.C, bus.N, bus.Z} = 4'b0000;

        //         addr   instr     A_out     vcnz  rw mb  as fs   dr   imdt      we ram       flags
        vecs[0]  = mk(6'h00, 16'hE0A0, 16'h0010, 4'h0, 0, 2'd0, 0, 4'h0, 4'h0, 16'h0000, 0, 16'h0000, 4'h0); // JR -> 0x10
        vecs[1]  = mk(6'h10, 16'h815A, 16'h0000, 4'hF, 1, 2'd1, 0, 4'h0, 4'h1, 16'h005A, 0, 16'h0000, 4'h0); // LDI R1,5A
        vecs[2]  = mk(6'h11, 16'hA203, 16'h0010, 4'h0, 0, 2'd0, 1, 4'h0, 4'h2, 16'h0000, 1, 16'h0010, 4'h0); // ST R2,R3
        vecs[3]  = mk(6'h12, 16'h9420, 16'h0033, 4'h0, 0, 2'd0, 0, 4'h0, 4'h4, 16'h0000, 0, 16'h0033, 4'h0); // LD R4,R2
        vecs[4]  = mk(6'h13, 16'h1123, 16'h0000, 4'h1, 1, 2'd0, 0, 4'h1, 4'h1, 16'h0000, 0, 16'h0033, 4'h1); // ALU Z=1
        vecs[5]  = mk(6'h14, 16'hC020, 16'h0000, 4'h0, 0, 2'd0, 0, 4'h0, 4'h0, 16'h0000, 0, 16'h0033, 4'h1); // BZ taken
        vecs[6]  = mk(6'h20, 16'h5456, 16'h0000, 4'h4, 1, 2'd0, 0, 4'h5, 4'h4, 16'h0000, 0, 16'h0033, 4'h4); // ALU Z=0
        vecs[7]  = mk(6'h21, 16'hC030, 16'h0000, 4'h1, 0, 2'd0, 0, 4'h0, 4'h0, 16'h0000, 0, 16'h0033, 4'h4); // BZ not taken
        vecs[8]  = mk(6'h22, 16'h2000, 16'h0000, 4'h2, 1, 2'd0, 0, 4'h2, 4'h0, 16'h0000, 0, 16'h0033, 4'h2); // ALU N=1
        vecs[9]  = mk(6'h23, 16'hD005, 16'h0000, 4'h0, 0, 2'd0, 0, 4'h0, 4'h0, 16'h0000, 0, 16'h0033, 4'h2); // BN taken
        vecs[10] = mk(6'h05, 16'hB73F, 16'h0000, 4'hF, 1, 2'd2, 0, 4'h0, 4'h7, 16'h0000, 0, 16'h0033, 4'h2); // JAL R7,3F
        vecs[11] = mk(6'h3F, 16'h7FFF, 16'h0000, 4'h8, 1, 2'd0, 0, 4'h7, 4'hF, 16'h0000, 0, 16'h0033, 4'h8); // ALU, wrap
        vecs[12] = mk(6'h00, 16'hE0A0, 16'h0028, 4'h0, 0, 2'd0, 0, 4'h0, 4'h0, 16'h0000, 0, 16'h0033, 4'h8); // JR -> 0x28

        for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
        for (int i = 0; i < 13; i++) rom[vecs[i].addr] = vecs[i].instr;
        rom[6'h28] = 16'hF000;   // HALT
        rom[6'h00] = 16'h1123;   // ALU op used for the reset-abort sequence

        // ---- Reset state, then reset asserted mid-EXEC of an ALU op ----
        tick();
        chk("rst_imem_addr", 0, bus.imem_addr, 6'h00);
        chk("rst_flags", 0, flags, 4'h0);
        chk("rst_halted", 0, halted, 1'b0);
        chk("rst_rw", 0, bus.RW, 1'b0);
        chk("rst_ram_addr", 0, bus.ram_addr, 16'h0000);
        reset = 1'b1;
        run   = 1'b1;
        {bus.V, bus.C, bus.N, bus.Z} = 4'b0001;
        tick();                                  // LOAD
        tick();                                  // EXEC
        chk("abort_pre_rw", 0, bus.RW, 1'b1);
        reset = 1'b0;
        #1;
        chk("abort_rw", 0, bus.RW, 1'b0);
        chk("abort_we", 0, bus.ram_we, 1'b0);
        chk("abort_pc", 0, bus.imem_addr, 6'h00);
        chk("abort_flags", 0, flags, 4'h0);
        chk("abort_halted", 0, halted, 1'b0);
        tick();
        chk("abort_flags_hold", 0, flags, 4'h0);
        chk("abort_rw_hold", 0, bus.RW, 1'b0);

        // ---- run=0 holds FETCH ----
        rom[6'h00] = vecs[0].instr;
        run   = 1'b0;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("stall_imem_addr", k, bus.imem_addr, 6'h00);
            chk("stall_rw", k, bus.RW, 1'b0);
        end
        run = 1'b1;

        // ---- Table-driven program ----
        for (int i = 0; i < 13; i++) begin
            logic [5:0] npc;
            npc = vecs[i].addr + 6'd1;
            bus.A_out = vecs[i].a;
            {bus.V, bus.C, bus.N, bus.Z} = vecs[i].vcnz;
            chk("fetch_addr", i, bus.imem_addr, vecs[i].addr);
            tick();                              // LOAD
            chk("load_strobes", i, {bus.RW, bus.ram_we}, 2'b00);
            tick();                              // EXEC
            chk("rw", i, bus.RW, vecs[i].rw);
            chk("mb", i, bus.MB, vecs[i].mb);
            chk("md", i, bus.MD, 1'b0);
            chk("asel", i, bus.ASEL, vecs[i].asel);
            chk("fs", i, bus.FS, vecs[i].fs);
            chk("dr", i, bus.DR, vecs[i].dr);
            chk("sa", i, bus.SA, vecs[i].instr[7:4]);
            chk("ba", i, bus.BA, vecs[i].instr[3:0]);
            chk("imdt", i, bus.imdt, vecs[i].imdt);
            chk("ram_we", i, bus.ram_we, vecs[i].we);
            chk("ram_addr", i, bus.ram_addr, vecs[i].ram);
            chk("pc_out", i, bus.PC, npc);
            chk("halted", i, halted, 1'b0);
            if (vecs[i].instr[15:12] == 4'h9) begin
                tick();                          // MEM
                chk("mem_md", i, bus.MD, 1'b1);
                chk("mem_rw", i, bus.RW, 1'b1);
                chk("mem_mb", i, bus.MB, 2'b00);
                chk("mem_dr", i, bus.DR, 4'h4);
                chk("mem_ram_addr", i, bus.ram_addr, 16'h0033);
                chk("mem_we", i, bus.ram_we, 1'b0);
            end
            tick();                              // back in FETCH
            chk("flags", i, flags, vecs[i].flg);
            if (vecs[i].we) begin
                chk("st_we_one_cycle", i, bus.ram_we, 1'b0);
                chk("st_ram_addr_held", i, bus.ram_addr, 16'h0010);
            end
        end

        // ---- run=0 before HALT, then HALT ----
        run = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("pre_halt_stall_addr", k, bus.imem_addr, 6'h28);
            chk("pre_halt_stall_halted", k, halted, 1'b0);
        end
        run = 1'b1;
        tick();                                  // LOAD
        tick();                                  // EXEC (HALT)
        chk("halt_exec_halted", 0, halted, 1'b0);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("halt_halted", k, halted, 1'b1);
            chk("halt_addr", k, bus.imem_addr, 6'h29);
            chk("halt_strobes", k, {bus.RW, bus.ram_we, bus.MD, bus.MB}, 5'b00000);
        end
        reset = 1'b0;
        #1;
        chk("halt_reset_halted", 0, halted, 1'b0);
        chk("halt_reset_pc", 0, bus.imem_addr, 6'h00);
        chk("halt_reset_flags", 0, flags, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/risc_control_unit.md
Name: risc_control_unit

Overview:
- Multi-cycle sequencer for the 16-bit RISC datapath.
- Fetches 16-bit instructions from a 64-word instruction ROM and decodes them.
- Drives every datapath select (MD, RW, ASEL, MB, FS, SA, DR, BA, imdt, PC) and the data-RAM strobes.
- Owns the 6-bit program counter, instruction register and latched ALU flags; the datapath holds no control state.

Parameters:
PC_W, 6, program counter / instruction address width
IMM_W, 8, immediate field width, zero-extended to 16 bits

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
run  in  1  1 = allowed to leave FETCH; 0 = hold in FETCH
imem_data  in  16  instruction ROM data, valid 1 cycle after imem_addr
V, C, N, Z  in  1 each  datapath ALU flags (combinational)
A_out  in  16  datapath bus A
imem_addr  out  6  instruction ROM address
MD, RW, ASEL  out  1 each  datapath selects
MB  out  2  datapath MB select
FS, SA, DR, BA  out  4 each  ALU function; A, dest and B register addresses
imdt  out  16  immediate to datapath
PC  out  6  PC value to datapath (MB=10 path)
ram_addr  out  16  data RAM address (registered)
ram_we  out  1  data RAM write strobe; write data is datapath B_out
halted  out  1  1 while in HALT
flags  out  4  latched {V,C,N,Z}

Behaviour:
- Instruction format: op=ir[15:12], rd=ir[11:8], rs=ir[7:4], rt=ir[3:0], imm8=ir[7:0], tgt=ir[5:0].
- Defaults, every state unless overridden: RW=0, ram_we=0, MD=0, MB=00, ASEL=0, FS=0, imdt=0. SA, DR, BA always driven from rs, rd, rt of ir.
- Reset (async, reset=0): state=FETCH, pc=0, ir=0, flags=0, ram_addr=0. All strobes 0.
- Reset mid-instruction aborts it; no RW or ram_we pulse may follow reset assertion.

States:
- FETCH: imem_addr=pc. If run=1, go to LOAD; else stay.
- LOAD: ir<=imem_data; pc<=pc+1 (mod 64; 63 wraps to 0); go to EXEC.
- EXEC, by op:
  - 0x0-0x7 ALU: FS={0,op[2:0]}, RW=1, MB=00, MD=0; flags<={V,C,N,Z}.
  - 0x8 LDI: MB=01, imdt={8'b0,imm8}, RW=1. Flags unchanged.
  - 0x9 LD: ram_addr<=A_out (reads R[rs]); go to MEM.
  - 0xA ST: ASEL=1 (AA=rd); ram_addr<=A_out; ram_we=1 for exactly this cycle. RAM[R[rd]]<=R[rt].
  - 0xB JAL: MB=10, PC=pc (already incremented), RW=1; pc<=tgt.
  - 0xC BZ: if flags Z=1, pc<=tgt.
  - 0xD BN: if flags N=1, pc<=tgt.
  - 0xE JR: pc<=A_out[5:0] (R[rs]).
  - 0xF HALT: go to HALT.
  - All ops except LD and HALT go to FETCH.
- MEM: MD=1, MB=00, RW=1 (R[rd]<=RAM data); go to FETCH.
- HALT: halted=1, all strobes 0, pc frozen. Only reset exits.

Cycle counts (run held 1):
- ALU, LDI, ST, JAL, branches, JR: 3 cycles.
- LD: 4 cycles.

Rules:
- ST ram_addr is registered in EXEC. The RAM samples a combinational address view in the same cycle, so ram_addr must equal A_out in EXEC.
- A taken branch or jump overrides the LOAD increment. The branch target is absolute.
- run=0 only stalls in FETCH; an instruction already in LOAD/EXEC/MEM completes.
- Flags update only on ALU ops. BZ/BN use flags from the most recent ALU op.

Test Plan:
- Reset check: reset=0 mid-EXEC of an ALU op -> RW stays 0; pc=0, state FETCH, flags=0, halted=0.
- LDI R1,0x5A -> in EXEC: RW=1, MB=01, DR=1, imdt=0x005A; next imem_addr=1 three cycles after the first fetch.
- ST then LD: ST R2,R3 with R2=0x0010 -> one-cycle ram_we, ram_addr=0x0010, ASEL=1. LD R4,R2 -> MEM cycle with MD=1, RW=1, DR=4; 4-cycle instruction.
- ALU op yielding Z=1, then BZ 0x20 -> pc=0x20. Repeat with an ALU op giving Z=0 -> pc falls through to next address.
- JAL 0x3F at address 0x05 -> R[rd]<=0x0006 via MB=10. Instruction at 0x3F (non-jump) -> next fetch address 0x00 (wrap).
- HALT -> halted=1, no further fetch, strobes stay 0 for 20 cycles. run=0 before HALT -> FETCH held, imem_addr stable.
